alu_op_sequencer: RTL

Parametrised successor to the ALU control decoder for the multi-cycle MIPS datapath. It accepts one funct code per handshake and drives the ALU, shifter, multiplier and result-mux select buses. It sequences iterative MULTU operations, and optionally DIVU, over WIDTH cycles. It raises busy/done/HI-LO write strobes so the controller no longer has to infer completion from the select code.

---
 rtl/alu_op_sequencer_pkg.sv | 50 +++++
 rtl/alu_op_sequencer_if.sv | 38 +++
 rtl/alu_op_sequencer_iter_counter.sv | 31 +++
 rtl/alu_op_sequencer.sv | 111 +++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: funct codes, the default
// completion select code, FSM state encoding and the funct classifier.
// DIVU_EN: when defined, DIVU (27) is classified as a multi-cycle op.
package alu_ctrl_pkg;

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;

  localparam logic [5:0] DONE_CODE_DEFAULT = 6'b111111;

  // Fixed state encodings kept stable so old controller dumps still decode.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ITER = ST_ITER,
    FIN  = ST_FIN
  } state_e;

  typedef enum logic [1:0] {
    OP_UNSUP  = 2'd0,
    OP_SINGLE = 2'd1,
    OP_MULTI  = 2'd2
  } op_class_e;

  // Classify a funct code as single-cycle, multi-cycle or unsupported.
  function automatic op_class_e decode_funct(input logic [5:0] f);
    op_class_e c;
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MFHI, F_MFLO: c = OP_SINGLE;
      F_MULTU: c = OP_MULTI;
`ifdef DIVU_EN
      F_DIVU: c = OP_MULTI;
`endif
      default: c = OP_UNSUP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Op handshake and select bus between the multi-cycle controller (master)
// and the ALU op sequencer (slave).
//
// Handshake: an op is accepted on a rising clk edge where op_valid and
// op_ready are both high; funct must be stable while op_valid is high.
// op_ready is low for the whole of a multi-cycle op and op_valid is ignored
// then. All other slave outputs are registered.
interface alu_op_sequencer_if
  import alu_ctrl_pkg::*;
#(
  parameter int SW = 6
) ();
  logic          op_valid;
  logic [5:0]    funct;
  logic          op_ready;
  logic [5:0]    alu_sel;
  logic [5:0]    sht_sel;
  logic [5:0]    mul_sel;
  logic [5:0]    mux_sel;
  logic          busy;
  logic          op_done;
  logic          hilo_we;
  logic          op_err;
  logic [SW-1:0] step;
  state_e        dbg_state;

  modport master (
    output op_valid, funct,
    input  op_ready, alu_sel, sht_sel, mul_sel, mux_sel,
    input  busy, op_done, hilo_we, op_err, step, dbg_state
  );

  modport slave (
    input  op_valid, funct,
    output op_ready, alu_sel, sht_sel, mul_sel, mux_sel,
    output busy, op_done, hilo_we, op_err, step, dbg_state
  );
endinterface

// File: rtl/alu_op_sequencer_iter_counter.sv
// Saturating up-counter with synchronous clear, count enable and a flag
// that is high when the next enabled increment lands on LIMIT.
module iter_counter #(
  parameter int LIMIT = 32,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LIM    = CW'(LIMIT);
  localparam logic [CW-1:0] LIM_M1 = CW'(LIMIT - 1);

  // Count up on enable, hold at LIMIT, clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIM)) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == LIM_M1);

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: accepts one funct per handshake, drives the four select
// buses with the same registered code and sequences MULTU (and DIVU when
// DIVU_EN is defined) over WIDTH cycles with busy/done/HI-LO strobes.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter logic [5:0] DONE_CODE = DONE_CODE_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  alu_op_sequencer_if.slave bus
);

  localparam int SW = $clog2(WIDTH + 1);

  state_e    state;
  logic [5:0] sel;
  logic       done_q;
  logic       hilo_q;
  logic       err_q;
  op_class_e  cls;
  logic       cnt_en;
  logic       cnt_clr;
  logic       cnt_tc;
  logic [SW-1:0] cnt;

  assign cls = decode_funct(bus.funct);

  // Step advances on a multi-cycle accept and on every ITER cycle; FIN clears it.
  assign cnt_en  = ((state == IDLE) && bus.op_valid && (cls == OP_MULTI)) ||
                   (state == ITER);
  assign cnt_clr = (state == FIN);

  iter_counter #(
    .LIMIT(WIDTH),
    .CW   (SW)
  ) u_step (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(cnt),
    .tc   (cnt_tc)
  );

  // Main FSM: select code, state and the one-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= '0;
      done_q <= 1'b0;
      hilo_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      hilo_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          sel <= '0;
          if (bus.op_valid) begin
            case (cls)
              OP_SINGLE: begin
                sel    <= bus.funct;
                done_q <= 1'b1;
              end
              OP_MULTI: begin
                sel   <= bus.funct;
                state <= ITER;
              end
              default: begin
                err_q <= 1'b1;
              end
            endcase
          end
        end
        ITER: begin
          // The op code holds until the edge where step reaches WIDTH.
          if (cnt_tc) begin
            state  <= FIN;
            sel    <= DONE_CODE;
            done_q <= 1'b1;
            hilo_q <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          sel   <= '0;
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
        end
      endcase
    end
  end

  assign bus.alu_sel   = sel;
  assign bus.sht_sel   = sel;
  assign bus.mul_sel   = sel;
  assign bus.mux_sel   = sel;
  assign bus.busy      = (state != IDLE);
  assign bus.op_ready  = (state == IDLE);
  assign bus.op_done   = done_q;
  assign bus.hilo_we   = hilo_q;
  assign bus.op_err    = err_q;
  assign bus.step      = cnt;
  assign bus.dbg_state = state;

endmodule
